// File: rtl/trace_mem_ctrl.sv
// trace_mem_ctrl: single-port trace memory controller and arbiter for the Tracer.
// Stores win the port; loads run a three-state IDLE/WAIT/GRANT sequence. Trace
// mode freezes the buffer after the post-trigger delay. Stream mode behaves as a
// FIFO.
module trace_mem_ctrl #(
  parameter int TRB_WIDTH = 32,
  parameter int DEPTH     = 64,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 FPGA_CLK_I,
  input  logic                 RST_I,
  input  logic [1:0]           MODE_I,
  input  logic [AW:0]          DELAY_I,
  input  logic                 TRG_EVENT_I,
  output logic                 TRG_DELAYED_O,
  input  logic                 STORE_I,
  input  logic [TRB_WIDTH-1:0] STORE_DATA_I,
  output logic                 STORE_PERM_O,
  input  logic                 LOAD_REQUEST_I,
  output logic                 LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0] LOAD_DATA_O,
  output logic                 MEM_EN_O,
  output logic                 MEM_WE_O,
  output logic [AW-1:0]        MEM_ADDR_O,
  output logic [TRB_WIDTH-1:0] MEM_WDATA_O,
  input  logic [TRB_WIDTH-1:0] MEM_RDATA_I,
  output logic [AW:0]          FILL_O
);

  typedef enum logic [1:0] {LD_IDLE, LD_WAIT, LD_GRANT} loadState_t;
  typedef enum logic [1:0] {TRG_ARMED, TRG_DELAY, TRG_DONE} trgState_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]           r_mode;
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [AW:0]          r_fill;
  logic [AW:0]          r_cnt;
  loadState_t           r_loadState;
  trgState_t            r_trgState;
  logic                 r_grant;
  logic                 r_trgDelayed;
  logic [TRB_WIDTH-1:0] r_loadData;

  logic          w_stream;
  logic          w_modeChange;
  logic          w_perm;
  logic          w_avail;
  logic          w_write;
  logic          w_read;
  logic [AW:0]   w_delaySat;
  logic [AW:0]   w_cntNext;
  logic [AW-1:0] w_wrPtrNext;
  logic          w_enterDone;

  // Any nonzero mode selects streaming; a mode edge restarts everything.
  assign w_stream     = (r_mode != 2'd0);
  assign w_modeChange = (MODE_I != r_mode);

  // Trace mode permits stores until frozen; stream mode until the FIFO is full.
  assign w_perm  = w_stream ? (r_fill < DEPTH_W) : (r_trgState != TRG_DONE);
  assign w_avail = w_stream ? (r_fill != '0) : 1'b1;

  // The store always owns the port; a read only issues in a store-free cycle.
  assign w_write = STORE_I & w_perm & ~w_modeChange;
  assign w_read  = (r_loadState == LD_IDLE) & LOAD_REQUEST_I & ~w_write & w_avail & ~w_modeChange;

  assign w_delaySat  = (DELAY_I > DEPTH_W) ? DEPTH_W : DELAY_I;
  assign w_cntNext   = r_cnt + {{AW{1'b0}}, w_write};
  assign w_wrPtrNext = r_wrPtr + {{(AW-1){1'b0}}, w_write};
  assign w_enterDone = ~w_stream & (r_trgState == TRG_DELAY) & (w_cntNext >= w_delaySat);

  // The memory port is driven straight from the arbitration result.
  assign MEM_EN_O    = w_write | w_read;
  assign MEM_WE_O    = w_write;
  assign MEM_ADDR_O  = w_write ? r_wrPtr : (w_read ? r_rdPtr : '0);
  assign MEM_WDATA_O = w_write ? STORE_DATA_I : '0;

  assign STORE_PERM_O  = w_perm;
  assign TRG_DELAYED_O = r_trgDelayed;
  assign LOAD_GRANT_O  = r_grant;
  assign LOAD_DATA_O   = r_loadData;
  assign FILL_O        = r_fill;

  // Track the registered mode so a change can be detected next cycle.
  always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_mode <= 2'd0;
    end else begin
      r_mode <= MODE_I;
    end
  end

  // Pointers and FIFO occupancy; entering DONE rewinds reads to the oldest word.
  always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_fill  <= '0;
    end else if (w_modeChange) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_fill  <= '0;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      if (w_enterDone) begin
        r_rdPtr <= w_wrPtrNext;
      end else if (w_read) begin
        r_rdPtr <= r_rdPtr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_stream) begin
        if (w_write) begin
          r_fill <= r_fill + {{AW{1'b0}}, 1'b1};
        end else if (w_read) begin
          r_fill <= r_fill - {{AW{1'b0}}, 1'b1};
        end
      end
    end
  end

  // Load sequencer: issue, capture read data, then pulse the grant.
  always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_loadState <= LD_IDLE;
      r_grant     <= 1'b0;
      r_loadData  <= '0;
    end else if (w_modeChange) begin
      r_loadState <= LD_IDLE;
      r_grant     <= 1'b0;
    end else begin
      r_grant <= 1'b0;
      case (r_loadState)
        LD_IDLE: begin
          if (w_read) begin
            r_loadState <= LD_WAIT;
          end
        end
        LD_WAIT: begin
          r_loadData  <= MEM_RDATA_I;
          r_grant     <= 1'b1;
          r_loadState <= LD_GRANT;
        end
        LD_GRANT: begin
          r_loadState <= LD_IDLE;
        end
        default: begin
          r_loadState <= LD_IDLE;
        end
      endcase
    end
  end

  // Trigger sequencer: count post-trigger writes, then freeze the buffer.
  always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_trgState   <= TRG_ARMED;
      r_cnt        <= '0;
      r_trgDelayed <= 1'b0;
    end else if (w_modeChange || w_stream) begin
      r_trgState   <= TRG_ARMED;
      r_cnt        <= '0;
      r_trgDelayed <= 1'b0;
    end else begin
      case (r_trgState)
        TRG_ARMED: begin
          if (TRG_EVENT_I) begin
            r_trgState <= TRG_DELAY;
            r_cnt      <= {{AW{1'b0}}, w_write};
          end
        end
        TRG_DELAY: begin
          r_cnt <= w_cntNext;
          if (w_enterDone) begin
            r_trgState   <= TRG_DONE;
            r_trgDelayed <= 1'b1;
          end
        end
        TRG_DONE: begin
          r_trgDelayed <= 1'b1;
        end
        default: begin
          r_trgState <= TRG_ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// tb_trace_mem_ctrl: scoreboard bench for trace_mem_ctrl with a 16-word memory.
// Expected writes and grants are queued as stimulus is applied and popped by a
// monitor whenever the DUT writes memory or pulses a grant.
module tb_trace_mem_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wrExp_t;

  typedef struct {
    logic [W-1:0] data;
    int           cycle;
  } loadExp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [AW:0]   delay;
  logic          trgEvent;
  logic          trgDelayed;
  logic          store;
  logic [W-1:0]  storeData;
  logic          storePerm;
  logic          loadRequest;
  logic          loadGrant;
  logic [W-1:0]  loadData;
  logic          memEn;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [W-1:0]  memWdata;
  logic [W-1:0]  memRdata;
  logic [AW:0]   fill;

  logic [W-1:0]  mem [DEPTH];
  wrExp_t        wrQ[$];
  loadExp_t      loadQ[$];
  wrExp_t        wrE;
  loadExp_t      ldE;
  int            cycleNum = 0;
  int            testsRun = 0;
  int            testsFailed = 0;

  trace_mem_ctrl #(.TRB_WIDTH(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .FPGA_CLK_I     (clock),
    .RST_I          (reset),
    .MODE_I         (mode),
    .DELAY_I        (delay),
    .TRG_EVENT_I    (trgEvent),
    .TRG_DELAYED_O  (trgDelayed),
    .STORE_I        (store),
    .STORE_DATA_I   (storeData),
    .STORE_PERM_O   (storePerm),
    .LOAD_REQUEST_I (loadRequest),
    .LOAD_GRANT_O   (loadGrant),
    .LOAD_DATA_O    (loadData),
    .MEM_EN_O       (memEn),
    .MEM_WE_O       (memWe),
    .MEM_ADDR_O     (memAddr),
    .MEM_WDATA_O    (memWdata),
    .MEM_RDATA_I    (memRdata),
    .FILL_O         (fill)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle numbering used to time grants against their issue.
  always @(posedge clock) cycleNum = cycleNum + 1;

  // Synchronous memory with a recognisable preload for never-written words.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (memEn) begin
      if (memWe) mem[memAddr] <= memWdata;
      else memRdata <= mem[memAddr];
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every memory write and every grant must match the head of its queue.
  always @(negedge clock) begin
    if (memEn && memWe) begin
      if (wrQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedWrite: got write to addr %0d data %h, expected none", memAddr, memWdata);
      end else begin
        wrE = wrQ.pop_front();
        checkOutput("writeAddr", 32'(memAddr), 32'(wrE.addr));
        checkOutput("writeData", memWdata, wrE.data);
      end
    end
    if (loadGrant) begin
      if (loadQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedGrant: got grant in cycle %0d data %h, expected none", cycleNum, loadData);
      end else begin
        ldE = loadQ.pop_front();
        checkOutput("loadData", loadData, ldE.data);
        checkOutput("grantCycle", 32'(cycleNum), 32'(ldE.cycle));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [W-1:0] d, input logic req);
    store       = st;
    storeData   = d;
    loadRequest = req;
    tick();
  endtask

  task automatic storeWord(input logic [W-1:0] d, input bit expectWrite, input logic [AW-1:0] addr);
    wrExp_t e;
    if (expectWrite) begin
      e.addr = addr;
      e.data = d;
      wrQ.push_back(e);
    end
    applyStimulus(1'b1, d, loadRequest);
    store     = 1'b0;
    storeData = '0;
  endtask

  task automatic expectLoad(input logic [W-1:0] d, input int cyc);
    loadExp_t e;
    e.data  = d;
    e.cycle = cyc;
    loadQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "TrgDelayed"}, 32'(trgDelayed), 32'd0);
    checkOutput({tag, "LoadGrant"}, 32'(loadGrant), 32'd0);
    checkOutput({tag, "LoadData"}, loadData, 32'd0);
    checkOutput({tag, "Fill"}, 32'(fill), 32'd0);
    checkOutput({tag, "MemEn"}, 32'(memEn), 32'd0);
    checkOutput({tag, "MemWe"}, 32'(memWe), 32'd0);
    checkOutput({tag, "MemAddr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "MemWdata"}, memWdata, 32'd0);
    checkOutput({tag, "StorePerm"}, 32'(storePerm), 32'd1);
  endtask

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    reset = 1'b1; mode = 2'd0; delay = 5'd4; trgEvent = 1'b0;
    store = 1'b0; storeData = '0; loadRequest = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkResetValues("reset");

    // Trace mode: 10 free stores, trigger, 4 counted stores, then frozen.
    for (int i = 0; i < 10; i++) begin
      storeWord(32'hA000_0000 + 32'(i), 1'b1, AW'(i));
      repeat (3) tick();
    end
    checkOutput("armedPerm", 32'(storePerm), 32'd1);
    trgEvent = 1'b1;
    tick();
    for (int i = 10; i < 14; i++) begin
      storeWord(32'hA000_0000 + 32'(i), 1'b1, AW'(i));
      if (i == 12) begin
        checkOutput("delayPerm", 32'(storePerm), 32'd1);
        checkOutput("delayTrg", 32'(trgDelayed), 32'd0);
      end
      repeat (3) tick();
    end
    checkOutput("doneTrg", 32'(trgDelayed), 32'd1);
    checkOutput("donePerm", 32'(storePerm), 32'd0);
    for (int i = 14; i < 17; i++) begin
      storeWord(32'hA000_0000 + 32'(i), 1'b0, '0);
      repeat (3) tick();
    end
    store = 1'b1; storeData = 32'hA000_0011;
    #1;
    checkOutput("store18MemWe", 32'(memWe), 32'd0);
    tick();
    store = 1'b0; storeData = '0;

    // Replay from the oldest word, wrapping past the end of the memory.
    s = cycleNum;
    expectLoad(32'hC0DE_000E, s + 2);
    expectLoad(32'hC0DE_000F, s + 5);
    expectLoad(32'hA000_0000, s + 8);
    expectLoad(32'hA000_0001, s + 11);
    loadRequest = 1'b1;
    repeat (10) tick();
    loadRequest = 1'b0;
    repeat (4) tick();

    // Stream mode: fill the FIFO, overflow store is dropped, one load.
    trgEvent = 1'b0;
    mode = 2'd1;
    tick();
    checkOutput("streamFill0", 32'(fill), 32'd0);
    checkOutput("streamTrg", 32'(trgDelayed), 32'd0);
    checkOutput("streamPerm", 32'(storePerm), 32'd1);
    for (int i = 0; i < DEPTH; i++) storeWord(32'hB000_0000 + 32'(i), 1'b1, AW'(i));
    checkOutput("fullFill", 32'(fill), 32'd16);
    checkOutput("fullPerm", 32'(storePerm), 32'd0);
    storeWord(32'hBFFF_FFFF, 1'b0, '0);
    checkOutput("overflowFill", 32'(fill), 32'd16);
    s = cycleNum;
    expectLoad(32'hB000_0000, s + 2);
    applyStimulus(1'b0, '0, 1'b1);
    loadRequest = 1'b0;
    checkOutput("popFill", 32'(fill), 32'd15);
    checkOutput("popPerm", 32'(storePerm), 32'd1);
    repeat (3) tick();

    // Collision: store and request together, read slips one cycle.
    s = cycleNum;
    wrE.addr = '0; wrE.data = 32'hD1D1_D1D1; wrQ.push_back(wrE);
    expectLoad(32'hB000_0001, s + 3);
    applyStimulus(1'b1, 32'hD1D1_D1D1, 1'b1);
    store = 1'b0; storeData = '0;
    #1;
    checkOutput("slipMemEn", 32'(memEn), 32'd1);
    checkOutput("slipMemWe", 32'(memWe), 32'd0);
    checkOutput("slipMemAddr", 32'(memAddr), 32'd1);
    tick();
    loadRequest = 1'b0;
    checkOutput("slipFill", 32'(fill), 32'd15);
    repeat (3) tick();

    // Empty FIFO: request stalls until a store arrives.
    mode = 2'd2;
    tick();
    checkOutput("emptyFill", 32'(fill), 32'd0);
    loadRequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("emptyNoRead", 32'(memEn), 32'd0);
      tick();
    end
    s = cycleNum;
    wrE.addr = '0; wrE.data = 32'hE5E5_E5E5; wrQ.push_back(wrE);
    expectLoad(32'hE5E5_E5E5, s + 3);
    applyStimulus(1'b1, 32'hE5E5_E5E5, 1'b1);
    store = 1'b0; storeData = '0;
    #1;
    checkOutput("emptyReadEn", 32'(memEn), 32'd1);
    checkOutput("emptyReadAddr", 32'(memAddr), 32'd0);
    tick();
    loadRequest = 1'b0;
    repeat (3) tick();

    // Mode change while the load waits: no grant, state cleared, data kept.
    storeWord(32'hF000_0000, 1'b1, AW'(1));
    storeWord(32'hF000_0001, 1'b1, AW'(2));
    applyStimulus(1'b0, '0, 1'b1);
    loadRequest = 1'b0;
    mode = 2'd0;
    tick();
    checkOutput("abortGrant", 32'(loadGrant), 32'd0);
    checkOutput("abortFill", 32'(fill), 32'd0);
    checkOutput("abortDataKept", loadData, 32'hE5E5_E5E5);
    tick();
    checkOutput("abortGrantLate", 32'(loadGrant), 32'd0);
    storeWord(32'h0600_D000, 1'b1, '0);
    s = cycleNum;
    expectLoad(32'h0600_D000, s + 2);
    applyStimulus(1'b0, '0, 1'b1);
    loadRequest = 1'b0;
    repeat (3) tick();

    // Asynchronous reset while a load waits for its data.
    applyStimulus(1'b0, '0, 1'b1);
    loadRequest = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("asyncReset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("postResetGrant", 32'(loadGrant), 32'd0);

    checkOutput("writesDrained", 32'(wrQ.size()), 32'd0);
    checkOutput("loadsDrained", 32'(loadQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
